// File: rtl/uart_rx_bit_sampler.sv
// uart_rx_bit_sampler: oversampling front end of the UART receiver (sync, edge/bit counting, bit resolve).
// Defining UART_RX_MAJORITY_EN builds the 3-sample majority vote; otherwise one centre sample is used.
module uart_rx_bit_sampler #(
    parameter int data_width = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       samp_en,
    input  logic [5:0] prescale,
    input  logic       par_en,
    input  logic       RX_IN,
    output logic       rx_sync,
    output logic       sampled_bit,
    output logic       sample_valid,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       bit_done,
    output logic       frame_done
);
    // Index of the stop bit when no parity bit is present (start + data).
    localparam logic [3:0] LAST_BIT_NO_PAR = 4'(data_width + 1);

    logic       sync1_q;
    logic       sync2_q;
    logic [5:0] p_q;
    logic [5:0] p_d;
    logic       par_q;
    logic       par_d;
    logic [5:0] edge_q;
    logic [5:0] edge_d;
    logic [3:0] bit_q;
    logic [3:0] bit_d;
    logic       samp_q;
    logic       samp_d;
    logic       valid_q;
    logic       valid_d;
    logic       bit_done_q;
    logic       bit_done_d;
    logic       frame_done_q;
    logic       frame_done_d;

    logic [5:0] p_dec;
    logic [5:0] half;
    logic [3:0] last_bit;
    logic       last_edge;

`ifdef UART_RX_MAJORITY_EN
    logic s0_q;
    logic s0_d;
    logic s1_q;
    logic s1_d;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= RX_IN;
            sync2_q <= sync1_q;
        end
    end

    // Illegal oversampling ratios fall back to 16.
    always_comb begin
        p_dec = 6'd16;
        case (prescale)
            6'd8, 6'd16, 6'd32: p_dec = prescale;
            default:            p_dec = 6'd16;
        endcase
    end

    assign half      = {1'b0, p_q[5:1]};
    assign last_edge = (edge_q == (p_q - 6'd1));
    assign last_bit  = LAST_BIT_NO_PAR + {3'b000, par_q};

    // Configuration is only sampled while idle so a frame always sees one P and one length.
    always_comb begin
        p_d          = p_q;
        par_d        = par_q;
        edge_d       = edge_q;
        bit_d        = bit_q;
        bit_done_d   = 1'b0;
        frame_done_d = 1'b0;
        if (!samp_en) begin
            p_d    = p_dec;
            par_d  = par_en;
            edge_d = 6'd0;
            bit_d  = 4'd0;
        end else if (last_edge) begin
            edge_d     = 6'd0;
            bit_done_d = 1'b1;
            if (bit_q == last_bit) begin
                bit_d        = 4'd0;
                frame_done_d = 1'b1;
            end else begin
                bit_d = bit_q + 4'd1;
            end
        end else begin
            edge_d = edge_q + 6'd1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    always_comb begin
        s0_d    = s0_q;
        s1_d    = s1_q;
        samp_d  = samp_q;
        valid_d = 1'b0;
        if (samp_en) begin
            if (edge_q == (half - 6'd1)) begin
                s0_d = sync2_q;
            end
            if (edge_q == half) begin
                s1_d = sync2_q;
            end
            if (edge_q == (half + 6'd1)) begin
                samp_d  = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s0_q <= 1'b1;
            s1_q <= 1'b1;
        end else begin
            s0_q <= s0_d;
            s1_q <= s1_d;
        end
    end
`else
    always_comb begin
        samp_d  = samp_q;
        valid_d = 1'b0;
        if (samp_en && (edge_q == half)) begin
            samp_d  = sync2_q;
            valid_d = 1'b1;
        end
    end
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            p_q          <= 6'd16;
            par_q        <= 1'b0;
            edge_q       <= 6'd0;
            bit_q        <= 4'd0;
            samp_q       <= 1'b1;
            valid_q      <= 1'b0;
            bit_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            p_q          <= p_d;
            par_q        <= par_d;
            edge_q       <= edge_d;
            bit_q        <= bit_d;
            samp_q       <= samp_d;
            valid_q      <= valid_d;
            bit_done_q   <= bit_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rx_sync      = sync2_q;
    assign sampled_bit  = samp_q;
    assign sample_valid = valid_q;
    assign edge_cnt     = edge_q;
    assign bit_cnt      = bit_q;
    assign bit_done     = bit_done_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// Self-checking bench for uart_rx_bit_sampler: frame scoreboard of resolved bits plus strobe/timing checks.
// Expectations follow the UART_RX_MAJORITY_EN setting of the build.
module tb_uart_rx_bit_sampler;
    localparam int W = 1;

    logic       clk;
    logic       rst_n;
    logic       samp_en;
    logic [5:0] prescale;
    logic       par_en;
    logic       rx_in;
    logic       rx_sync;
    logic       sampled_bit;
    logic       sample_valid;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       bit_done;
    logic       frame_done;

    uart_rx_bit_sampler #(.data_width(8)) dut (
        .CLK          (clk),
        .RST          (rst_n),
        .samp_en      (samp_en),
        .prescale     (prescale),
        .par_en       (par_en),
        .RX_IN        (rx_in),
        .rx_sync      (rx_sync),
        .sampled_bit  (sampled_bit),
        .sample_valid (sample_valid),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .bit_done     (bit_done),
        .frame_done   (frame_done)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_exp;
    int checks = 0;
    int failures = 0;
    int start_cyc = 0;
    int bd_cnt = 0;
    int fd_cnt = 0;
    int fd_rel = -1;
    int sv_cnt = 0;
    int sv_first_rel = -1;
    int strobe_cnt = 0;

    logic bits_arr[16];
    int cur_p = 16;
    int g_bit_s = -1;
    int g_lo_s = 0;
    int g_hi_s = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line value seen on rx_sync during frame-relative cycle k.
    function automatic logic want_sync(input int k);
        int b;
        int e;
        if (k < 0) return 1'b1;
        b = k / cur_p;
        e = k % cur_p;
        if (b >= 16) return 1'b1;
        if (b == g_bit_s && e >= g_lo_s && e <= g_hi_s) return 1'b0;
        return bits_arr[b];
    endfunction

    function automatic logic model_bit(input int b, input int h);
        logic a;
        logic m;
        logic z;
        int base;
        base = b * cur_p;
`ifdef UART_RX_MAJORITY_EN
        a = want_sync(base + h - 1);
        m = want_sync(base + h);
        z = want_sync(base + h + 1);
        return (a & m) | (a & z) | (m & z);
`else
        a = want_sync(base + h);
        m = a;
        z = a;
        return a & m & z;
`endif
    endfunction

    // monitor: pops the scoreboard on each resolved bit and tallies strobes
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (sample_valid || bit_done || frame_done) strobe_cnt++;
        if (sample_valid) begin
            sv_cnt++;
            if (sv_first_rel < 0) sv_first_rel = cyc - start_cyc;
            check_eq("exp_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("sampled_bit", 32'(sampled_bit), 32'(e));
            end
        end
        if (bit_done) bd_cnt++;
        if (frame_done) begin
            fd_cnt++;
            fd_rel = cyc - start_cyc;
            check_eq("bit_cnt_wrap", 32'(bit_cnt), 32'd0);
            check_eq("fd_with_bd", 32'(bit_done), 32'd1);
        end
    end

    // driver: one frame, optionally glitched, aborted or cut by async reset (-1 = unused)
    task automatic run_frame(input int p_in, input bit par, input logic [7:0] data, input bit pbit,
                             input int g_bit, input int g_lo, input int g_hi,
                             input int abort_at, input int reset_at, input int mid_ps);
        int p_eff;
        int h;
        int len;
        int total;
        int stop;
        int upd;
        int pushed;
        int exp_bd;
        bit full;
        logic e;
        p_eff = (p_in == 8 || p_in == 16 || p_in == 32) ? p_in : 16;
        h = p_eff / 2;
        len = 10 + int'(par);
        total = len * p_eff;
        stop = total;
        if (abort_at >= 0) stop = abort_at;
        if (reset_at >= 0) stop = reset_at;
        full = (stop == total);
        for (int i = 0; i < 16; i++) bits_arr[i] = 1'b1;
        bits_arr[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits_arr[i + 1] = data[i];
        if (par) bits_arr[9] = pbit;
        cur_p = p_eff;
        g_bit_s = g_bit;
        g_lo_s = g_lo;
        g_hi_s = g_hi;

        samp_en = 1'b0;
        prescale = 6'(p_in);
        par_en = par;
        rx_in = 1'b1;
        repeat (3) tick();
        bd_cnt = 0;
        fd_cnt = 0;
        fd_rel = -1;
        sv_cnt = 0;
        sv_first_rel = -1;

        pushed = 0;
        for (int b = 0; b < len; b++) begin
`ifdef UART_RX_MAJORITY_EN
            upd = b * p_eff + h + 1;
`else
            upd = b * p_eff + h;
`endif
            if (upd < stop - ((reset_at >= 0) ? 1 : 0)) begin
                e = model_bit(b, h);
                exp_q.push_back(e);
                last_exp = e;
                pushed++;
            end
        end

        for (int c = -2; c < stop + 3; c++) begin
            rx_in = want_sync(c + 2);
            samp_en = (c >= 0 && c < stop);
            if (mid_ps >= 0 && c == 20) prescale = 6'(mid_ps);
            if (c == 0) start_cyc = cyc;
            if (abort_at >= 0 && c == abort_at) begin
                #5;
                check_eq("abort_edge_before", 32'(edge_cnt), 32'(abort_at % p_eff));
                check_eq("abort_bit_before", 32'(bit_cnt), 32'(abort_at / p_eff));
            end
            if (abort_at >= 0 && c == abort_at + 1) begin
                #5;
                check_eq("abort_edge_clear", 32'(edge_cnt), 32'd0);
                check_eq("abort_bit_clear", 32'(bit_cnt), 32'd0);
            end
            if (reset_at >= 0 && c == reset_at) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_eq("arst_rx_sync", 32'(rx_sync), 32'd1);
                check_eq("arst_sampled_bit", 32'(sampled_bit), 32'd1);
                check_eq("arst_edge_cnt", 32'(edge_cnt), 32'd0);
                check_eq("arst_bit_cnt", 32'(bit_cnt), 32'd0);
                check_eq("arst_strobes", 32'({sample_valid, bit_done, frame_done}), 32'd0);
            end
            tick();
        end
        if (reset_at >= 0) rst_n = 1'b1;

        exp_bd = full ? len : ((reset_at >= 0) ? (stop - 1) / p_eff : stop / p_eff);
        check_eq("bit_done_count", 32'(bd_cnt), 32'(exp_bd));
        check_eq("frame_done_count", 32'(fd_cnt), full ? 32'd1 : 32'd0);
        check_eq("sample_valid_count", 32'(sv_cnt), 32'(pushed));
        check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
        if (full) check_eq("frame_done_cycle", 32'(fd_rel), 32'(total));
`ifdef UART_RX_MAJORITY_EN
        if (pushed > 0) check_eq("sample_valid_cycle", 32'(sv_first_rel), 32'(h + 2));
`else
        if (pushed > 0) check_eq("sample_valid_cycle", 32'(sv_first_rel), 32'(h + 1));
`endif
        if (reset_at >= 0) check_eq("sampled_bit_after_reset", 32'(sampled_bit), 32'd1);
        else check_eq("sampled_bit_held", 32'(sampled_bit), 32'(last_exp));
        exp_q.delete();
    endtask

    initial begin
        int pr;
        rst_n = 1'b0;
        samp_en = 1'b0;
        prescale = 6'd16;
        par_en = 1'b0;
        rx_in = 1'b1;
        last_exp = 1'b1;
        repeat (3) tick();
        check_eq("rst_rx_sync", 32'(rx_sync), 32'd1);
        check_eq("rst_sampled_bit", 32'(sampled_bit), 32'd1);
        check_eq("rst_edge_cnt", 32'(edge_cnt), 32'd0);
        check_eq("rst_bit_cnt", 32'(bit_cnt), 32'd0);
        check_eq("rst_strobes", 32'({sample_valid, bit_done, frame_done}), 32'd0);
        rst_n = 1'b1;
        strobe_cnt = 0;
        repeat (100) tick();
        check_eq("idle_strobes", 32'(strobe_cnt), 32'd0);
        check_eq("idle_edge_cnt", 32'(edge_cnt), 32'd0);

        rx_in = 1'b0;
        tick();
        check_eq("sync_lag1", 32'(rx_sync), 32'd1);
        tick();
        check_eq("sync_lag2", 32'(rx_sync), 32'd0);
        rx_in = 1'b1;
        repeat (2) tick();

        run_frame(16, 1'b0, 8'hA5, 1'b0, -1, 0, -1, -1, -1, -1);
        run_frame(8, 1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), -1, 0, -1, -1, -1, -1);
        run_frame(32, 1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), -1, 0, -1, -1, -1, -1);
        run_frame(5, 1'b0, 8'($urandom_range(0, 255)), 1'b0, -1, 0, -1, -1, -1, -1);
        run_frame(16, 1'b0, 8'($urandom_range(0, 255)), 1'b0, -1, 0, -1, -1, -1, 8);
        run_frame(16, 1'b0, 8'hFF, 1'b0, 1, 8, 8, -1, -1, -1);
        run_frame(16, 1'b0, 8'hFF, 1'b0, 1, 7, 8, -1, -1, -1);
        run_frame(16, 1'b0, 8'($urandom_range(0, 255)), 1'b0, -1, 0, -1, 73, -1, -1);
        run_frame(16, 1'b0, 8'($urandom_range(0, 255)), 1'b0, -1, 0, -1, -1, 53, -1);
        for (int n = 0; n < 3; n++) begin
            case ($urandom_range(0, 2))
                0: pr = 8;
                1: pr = 16;
                default: pr = 32;
            endcase
            run_frame(pr, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                      1'($urandom_range(0, 1)), -1, 0, -1, -1, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
